fetch_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/fetch_prefetch_buf.sv | 64 ++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Types and constants shared by the fetch stage and its helpers.
//   word_t        : 32-bit machine word
//   fetch_state_t : fetch sequencer states
//   PC_STEP       : byte distance between consecutive instructions
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_buf
// One-entry holding buffer for a word fetched while decode is stalled.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i/npc_i into the entry
//   data_i, npc_i : fetched word and its address + 4
//   flush_i       : discard the entry (redirect / halt); wins over load_i
//   take_i        : entry has been moved into IF/ID
//   data_o, npc_o, valid_o : entry contents
// ----------------------------------------------------------------------------
module fetch_prefetch_buf
    import cpu_types_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] npc_i,
    input  logic         flush_i,
    input  logic         take_i,
    output logic [W-1:0] data_o,
    output logic [W-1:0] npc_o,
    output logic         valid_o
);

    logic [W-1:0] data_q, data_d;
    logic [W-1:0] npc_q, npc_d;
    logic         valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end else if (take_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory with an iREN/ihit handshake and holds each returned word in a
// registered IF/ID register feeding decode.
// Optional feature macro: FETCH_PREFETCH_EN (one-entry prefetch buffer that
// keeps fetching one word ahead during a decode stall).
// Ports:
//   CLK, nRST        : clock, asynchronous active-low reset
//   iREN, iaddr      : instruction read request / address (= PC)
//   ihit, iload      : memory response strobe and data
//   stall            : decode cannot consume the held instruction
//   redirect, redirect_pc : jump/branch target load and flush
//   halt             : decode saw HALT in imemload
//   imemload, npc    : held instruction and its address + 4
//   instr_valid      : imemload is live
//   halted           : sticky halt indication
// ----------------------------------------------------------------------------
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned          WORD_W  = 32,
    parameter logic [WORD_W-1:0]    PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] npc,
    output logic              instr_valid,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic              valid_q, valid_d;
    logic              iren;
    logic [WORD_W-1:0] pc_inc;

    logic              buf_load, buf_flush, buf_take;
    logic              buf_valid;
    logic [WORD_W-1:0] buf_data, buf_npc;

    assign pc_inc = pc_q + WORD_W'(PC_STEP);

`ifdef FETCH_PREFETCH_EN
    localparam bit PREF_EN = 1'b1;

    fetch_prefetch_buf #(
        .W (WORD_W)
    ) u_pbuf (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .load_i  (buf_load),
        .data_i  (iload),
        .npc_i   (pc_inc),
        .flush_i (buf_flush),
        .take_i  (buf_take),
        .data_o  (buf_data),
        .npc_o   (buf_npc),
        .valid_o (buf_valid)
    );
`else
    localparam bit PREF_EN = 1'b0;

    logic buf_unused;
    assign buf_unused = ^{buf_load, buf_flush, buf_take};
    assign buf_valid  = 1'b0;
    assign buf_data   = '0;
    assign buf_npc    = '0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        npc_d     = npc_q;
        valid_d   = valid_q;
        iren      = 1'b0;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // With the buffer, requests continue through a stall until the
                // buffer is full; without it, a stalled held word blocks fetch.
                iren = PREF_EN ? !buf_valid : !(valid_q && stall);
                if (halt && valid_q) begin
                    state_d   = HALTED;
                    valid_d   = 1'b0;
                    buf_flush = 1'b1;
                end else if (redirect && valid_q) begin
                    pc_d      = {redirect_pc[WORD_W-1:2], 2'b00};
                    valid_d   = 1'b0;
                    buf_flush = 1'b1;
                end else if (ihit && iren) begin
                    pc_d = pc_inc;
                    if (valid_q && stall) begin
                        buf_load = 1'b1;
                    end else begin
                        ir_d    = iload;
                        npc_d   = pc_inc;
                        valid_d = 1'b1;
                    end
                end else if (valid_q && !stall) begin
                    if (buf_valid) begin
                        ir_d     = buf_data;
                        npc_d    = buf_npc;
                        buf_take = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            ir_q    <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign iREN        = iren;
    assign iaddr       = pc_q;
    assign imemload    = ir_q;
    assign npc         = npc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed stimulus with a behavioural reference of the fetch stage that is
// compared against the DUT every falling clock edge, plus literal checks.
// Honours FETCH_PREFETCH_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imemload;
    logic [31:0] npc;
    logic        instr_valid;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .WORD_W  (32),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .ihit        (ihit),
        .iload       (iload),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imemload    (imemload),
        .npc         (npc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural reference ----------------
    typedef struct {
        logic [31:0] d;
        logic [31:0] n;
    } ent_t;

    bit          m_started;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_npc;
    bit          m_valid;
    ent_t        m_buf[$];
    bit          m_en;

    function automatic bit m_iren();
        if (!m_started || m_halted) return 1'b0;
        if (PREF) return (m_buf.size() == 0);
        return !(m_valid && stall);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_started = 1'b0;
            m_halted  = 1'b0;
            m_pc      = 32'h0;
            m_ir      = 32'h0;
            m_npc     = 32'h0;
            m_valid   = 1'b0;
            m_buf.delete();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_halted) begin
            m_en = m_iren();
            if (halt && m_valid) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
                m_buf.delete();
            end else if (redirect && m_valid) begin
                m_pc    = redirect_pc & 32'hFFFF_FFFC;
                m_valid = 1'b0;
                m_buf.delete();
            end else if (ihit && m_en) begin
                if (m_valid && stall) begin
                    m_buf.push_back('{d: iload, n: m_pc + 32'd4});
                end else begin
                    m_ir    = iload;
                    m_npc   = m_pc + 32'd4;
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end else if (m_valid && !stall) begin
                if (m_buf.size() != 0) begin
                    m_ir  = m_buf[0].d;
                    m_npc = m_buf[0].n;
                    void'(m_buf.pop_front());
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("cyc_iREN",        {31'd0, iREN},        {31'd0, m_iren()});
        chk("cyc_iaddr",       iaddr,                m_pc);
        chk("cyc_imemload",    imemload,             m_ir);
        chk("cyc_npc",         npc,                  m_npc);
        chk("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("cyc_halted",      {31'd0, halted},      {31'd0, m_halted});
    end

    // ---------------- stimulus ----------------
    task automatic edge_();
        @(posedge CLK);
        #2;
    endtask

    task automatic drv(input logic h, input logic [31:0] ld, input logic st,
                       input logic rd, input logic [31:0] rp, input logic hl);
        ihit        = h;
        iload       = ld;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        halt        = hl;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iREN"},     {31'd0, iREN},        32'd0);
        chk({tag, "_iaddr"},    iaddr,                32'h0);
        chk({tag, "_imemload"}, imemload,             32'h0);
        chk({tag, "_npc"},      npc,                  32'h0);
        chk({tag, "_valid"},    {31'd0, instr_valid}, 32'd0);
        chk({tag, "_halted"},   {31'd0, halted},      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        ihit = 1'b0; iload = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        edge_();
        edge_();
        chk_reset("rst");

        // Reset release: IDLE for one edge, then request at PC_INIT
        nRST = 1'b1;
        idle();
        chk("idle_iREN", {31'd0, iREN}, 32'd0);
        edge_();
        idle();
        chk("t1_iREN_up", {31'd0, iREN}, 32'd1);
        chk("t1_iaddr0",  iaddr,         32'h0);
        drv(1'b1, 32'h3C01_0001, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        idle();
        chk("t1_imemload", imemload,             32'h3C01_0001);
        chk("t1_valid",    {31'd0, instr_valid}, 32'd1);
        chk("t1_npc",      npc,                  32'h4);
        chk("t1_iaddr",    iaddr,                32'h4);

        // Stall for 3 cycles on a held instruction
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
`ifndef FETCH_PREFETCH_EN
        chk("t2_iREN_stall", {31'd0, iREN}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            edge_();
            chk("t2_hold_ir",    imemload,             32'h3C01_0001);
            chk("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_hold_iaddr", iaddr,                32'h4);
        end
        idle();
        chk("t2_iREN_rel", {31'd0, iREN}, 32'd1);
        edge_();
        idle();
        chk("t2_consumed", {31'd0, instr_valid}, 32'd0);
        chk("t2_resume",   iaddr,                32'h4);

        // Back-to-back fetches, one per cycle
        drv(1'b1, 32'h2001_0002, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        drv(1'b1, 32'h2002_0003, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        idle();
        chk("tp_imemload", imemload, 32'h2002_0003);
        chk("tp_npc",      npc,      32'hC);
        chk("tp_iaddr",    iaddr,    32'hC);

        // Redirect in the same cycle as ihit: word discarded, target aligned
        drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        edge_();
        idle();
        chk("t3_valid",    {31'd0, instr_valid}, 32'd0);
        chk("t3_iaddr",    iaddr,                32'h100);
        chk("t3_imemload", imemload,             32'h2002_0003);

        // Redirect with nothing held is ignored
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
        edge_();
        idle();
        chk("rd_ignored", iaddr, 32'h100);

        drv(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        idle();
        chk("t4_ir",  imemload, 32'hFFFF_FFFF);
        chk("t4_npc", npc,      32'h104);

        // Halt, then a redirect that must be ignored
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        edge_();
        idle();
        chk("t4_halted", {31'd0, halted},      32'd1);
        chk("t4_iREN",   {31'd0, iREN},        32'd0);
        chk("t4_valid",  {31'd0, instr_valid}, 32'd0);
        drv(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h200, 1'b0);
        edge_();
        edge_();
        idle();
        chk("t4_frozen_iaddr", iaddr,           32'h104);
        chk("t4_still_halted", {31'd0, halted}, 32'd1);
        chk("t4_frozen_ir",    imemload,        32'hFFFF_FFFF);

        // Leave HALTED via reset, then set up an outstanding request at 0x40
        nRST = 1'b0;
        #1;
        chk_reset("hrst");
        edge_();
        nRST = 1'b1;
        edge_();
        drv(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        edge_();
        idle();
        chk("t5_iREN",  {31'd0, iREN}, 32'd1);
        chk("t5_iaddr", iaddr,         32'h40);

        // Asynchronous reset mid-request, late ihit ignored
        nRST = 1'b0;
        #1;
        chk_reset("t5_async");
        drv(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        nRST = 1'b1;
        edge_();
        idle();
        chk_reset_after_late();

        // PC wrap at the top of the address space
        drv(1'b1, 32'hAAAA_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        drv(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        edge_();
        idle();
        chk("wrap_target", iaddr, 32'hFFFF_FFFC);
        drv(1'b1, 32'hBBBB_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        edge_();
        idle();
        chk("wrap_iaddr", iaddr,    32'h0);
        chk("wrap_npc",   npc,      32'h0);
        chk("wrap_ir",    imemload, 32'hBBBB_0000);

`ifdef FETCH_PREFETCH_EN
        // Stall across two fetch attempts: only one word is buffered
        drv(1'b1, 32'hCCCC_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_iREN_stall", {31'd0, iREN}, 32'd1);
        edge_();
        drv(1'b1, 32'hDDDD_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_iaddr_once", iaddr,         32'h4);
        chk("t6_iREN_full",  {31'd0, iREN}, 32'd0);
        chk("t6_ir_held",    imemload,      32'hBBBB_0000);
        edge_();
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_iaddr_still", iaddr, 32'h4);
        edge_();
        idle();
        chk("t6_ir_buf",  imemload,             32'hCCCC_0000);
        chk("t6_npc_buf", npc,                  32'h4);
        chk("t6_valid",   {31'd0, instr_valid}, 32'd1);
        chk("t6_iREN",    {31'd0, iREN},        32'd1);
`endif

        edge_();
        edge_();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic chk_reset_after_late();
        chk("t5_late_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_late_ir",    imemload,             32'h0);
        chk("t5_late_npc",   npc,                  32'h0);
        chk("t5_late_iaddr", iaddr,                32'h0);
    endtask

endmodule
